ubus_xfer_ctrl: RTL and testbench

Parametrised, registered successor to the combinational shared write bus.
- Accepts one micro-instruction per cycle over a valid/ready handshake.
- Moves a value from one of NUM_SRC producers, or from the immediate, to one of NUM_DST consumers through a registered bus stage with consumer back-pressure.
- Owns the micro-PC: branch resolution, jump, and call/return through a small return-address stack (RAS).

---
 rtl/ubus_xfer_ctrl_if.sv | 50 +++++
 rtl/ubus_xfer_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_ubus_xfer_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ubus_xfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// ubus_xfer_ctrl_if
// Bundles the micro-instruction handshake and the shared-bus producer/consumer
// signals of ubus_xfer_ctrl.
//   master : micro-sequencer / environment side (drives instructions, producer
//            values, consumer contents and busy flags)
//   slave  : ubus_xfer_ctrl side (drives minst_ready, bus_data, dst_we)
// Signals:
//   minst_valid, minst_ready   instruction handshake
//   minst_type                 0 NOP,1 MOVE,2 MOVI,3 BREQ,4 JMP,5 CALL,6 RET,7 rsvd/BRGT
//   src_sel, dst_sel           producer / consumer index
//   imm, mbranch_target        immediate / compare value, branch target
//   src_data, dst_data         flattened producer values / consumer contents
//   dst_busy                   per-consumer back-pressure
//   bus_data, dst_we           registered bus value and one-hot write strobe
// ---------------------------------------------------------------------------
interface ubus_xfer_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 8,
  parameter int NUM_DST    = 8,
  parameter int MPC_WIDTH  = 8
) ();
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int DST_W = $clog2(NUM_DST);

  logic                          minst_valid;
  logic                          minst_ready;
  logic [2:0]                    minst_type;
  logic [SRC_W-1:0]              src_sel;
  logic [DST_W-1:0]              dst_sel;
  logic [DATA_WIDTH-1:0]         imm;
  logic [MPC_WIDTH-1:0]          mbranch_target;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_DST*DATA_WIDTH-1:0] dst_data;
  logic [NUM_DST-1:0]            dst_busy;
  logic [DATA_WIDTH-1:0]         bus_data;
  logic [NUM_DST-1:0]            dst_we;

  modport master (
    output minst_valid, minst_type, src_sel, dst_sel, imm, mbranch_target,
    output src_data, dst_data, dst_busy,
    input  minst_ready, bus_data, dst_we
  );

  modport slave (
    input  minst_valid, minst_type, src_sel, dst_sel, imm, mbranch_target,
    input  src_data, dst_data, dst_busy,
    output minst_ready, bus_data, dst_we
  );
endinterface

// File: rtl/ubus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// ubus_xfer_ctrl
// Registered shared-bus transfer controller with micro-PC sequencing.
// Accepts one micro-instruction per cycle (valid/ready), moves a producer
// value or immediate to one consumer through a registered output stage that
// honours consumer back-pressure, and owns the micro-PC including
// branch/jump/call/return via a circular return-address stack.
//
// Ports:
//   sys_clk        system clock, rising edge
//   sys_rst_n      asynchronous active-low reset
//   ubus           ubus_xfer_ctrl_if.slave (handshake + bus signals)
//   m_pc           micro-PC
//   illegal_op     sticky: reserved instruction type accepted
//   ras_overflow   sticky: CALL with the RAS full (oldest entry overwritten)
//   ras_underflow  sticky: RET with the RAS empty
//
// Build option: define UBUS_BRANCH_GT_EN to turn type 7 into BRGT
// (unsigned greater-than branch); otherwise type 7 is NOP + illegal_op.
// ---------------------------------------------------------------------------
module ubus_xfer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 8,
  parameter int NUM_DST    = 8,
  parameter int MPC_WIDTH  = 8,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  ubus_xfer_ctrl_if.slave      ubus,
  output logic [MPC_WIDTH-1:0] m_pc,
  output logic                 illegal_op,
  output logic                 ras_overflow,
  output logic                 ras_underflow
);

  localparam int SRC_W     = $clog2(NUM_SRC);
  localparam int DST_W     = $clog2(NUM_DST);
  localparam int RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] OP_MOVE = 3'd1;
  localparam logic [2:0] OP_MOVI = 3'd2;
  localparam logic [2:0] OP_BREQ = 3'd3;
  localparam logic [2:0] OP_JMP  = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [0:0] {
    OUT_IDLE = 1'b0,
    OUT_PEND = 1'b1
  } out_state_t;

  // Registered state
  out_state_t            out_state_reg, out_state_next;
  logic [NUM_DST-1:0]    dst_we_reg, dst_we_next;
  logic [DATA_WIDTH-1:0] bus_data_reg, bus_data_next;
  logic [MPC_WIDTH-1:0]  m_pc_reg, m_pc_next;
  logic                  illegal_op_reg;
  logic                  ras_overflow_reg;
  logic                  ras_underflow_reg;
  logic [MPC_WIDTH-1:0]  ras_mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0]  ras_wr_ptr_reg;   // next free slot; top is one below
  logic [RAS_CNT_W-1:0]  ras_count_reg;

  // Combinational helpers
  logic [DATA_WIDTH-1:0] src_vec [NUM_SRC];
  logic [DATA_WIDTH-1:0] dst_vec [NUM_DST];
  logic                  src_ok;
  logic                  dst_ok;
  logic                  pend_busy;
  logic                  accept;
  logic [DATA_WIDTH-1:0] dst_cur;
  logic [NUM_DST-1:0]    dst_onehot;
  logic [MPC_WIDTH-1:0]  pc_inc;
  logic [RAS_PTR_W-1:0]  ras_ptr_inc;
  logic [RAS_PTR_W-1:0]  ras_ptr_dec;
  logic [MPC_WIDTH-1:0]  ras_top;
  logic                  ras_full;
  logic                  ras_push;
  logic                  ras_pop;
  logic                  illegal_set;
  logic                  overflow_set;
  logic                  underflow_set;

  // Unflatten producer / consumer vectors
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_vec[gi] = ubus.src_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar gi = 0; gi < NUM_DST; gi++) begin : g_dst
      assign dst_vec[gi] = ubus.dst_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Index range checks; trivially true when the count is a power of two
  generate
    if (NUM_SRC == (1 << SRC_W)) begin : g_src_full
      assign src_ok = 1'b1;
    end else begin : g_src_part
      assign src_ok = (ubus.src_sel < SRC_W'(NUM_SRC));
    end
    if (NUM_DST == (1 << DST_W)) begin : g_dst_full
      assign dst_ok = 1'b1;
    end else begin : g_dst_part
      assign dst_ok = (ubus.dst_sel < DST_W'(NUM_DST));
    end
  endgenerate

  // dst_we_reg is one-hot or zero, so masking with dst_busy picks out
  // dst_busy[pending_dst] while PEND and yields 0 while IDLE.
  assign pend_busy  = |(dst_we_reg & ubus.dst_busy);
  assign accept     = ubus.minst_valid && !pend_busy;
  assign dst_cur    = dst_vec[ubus.dst_sel];
  assign dst_onehot = {{(NUM_DST-1){1'b0}}, 1'b1} << ubus.dst_sel;
  assign pc_inc     = m_pc_reg + MPC_WIDTH'(1);

  assign ras_ptr_inc = (ras_wr_ptr_reg == RAS_PTR_W'(RAS_DEPTH - 1)) ? '0
                                                                   : ras_wr_ptr_reg + RAS_PTR_W'(1);
  assign ras_ptr_dec = (ras_wr_ptr_reg == '0) ? RAS_PTR_W'(RAS_DEPTH - 1)
                                              : ras_wr_ptr_reg - RAS_PTR_W'(1);
  assign ras_top     = ras_mem[ras_ptr_dec];
  assign ras_full    = (ras_count_reg == RAS_CNT_W'(RAS_DEPTH));

  // Next-state / decode
  always_comb begin
    out_state_next = out_state_reg;
    dst_we_next    = dst_we_reg;
    bus_data_next  = bus_data_reg;
    m_pc_next      = m_pc_reg;
    ras_push       = 1'b0;
    ras_pop        = 1'b0;
    illegal_set    = 1'b0;
    overflow_set   = 1'b0;
    underflow_set  = 1'b0;

    // Pending write drains whenever its consumer is not busy
    if (out_state_reg == OUT_PEND && !pend_busy) begin
      out_state_next = OUT_IDLE;
      dst_we_next    = '0;
    end

    if (accept) begin
      m_pc_next = pc_inc;
      case (ubus.minst_type)
        OP_MOVE: begin
          if (src_ok && dst_ok) begin
            out_state_next = OUT_PEND;
            dst_we_next    = dst_onehot;
            bus_data_next  = src_vec[ubus.src_sel];
          end
        end
        OP_MOVI: begin
          if (dst_ok) begin
            out_state_next = OUT_PEND;
            dst_we_next    = dst_onehot;
            bus_data_next  = ubus.imm;
          end
        end
        OP_BREQ: begin
          if (dst_ok && dst_cur == ubus.imm) m_pc_next = ubus.mbranch_target;
        end
        OP_JMP: begin
          m_pc_next = ubus.mbranch_target;
        end
        OP_CALL: begin
          ras_push     = 1'b1;
          overflow_set = ras_full;
          m_pc_next    = ubus.mbranch_target;
        end
        OP_RET: begin
          if (ras_count_reg != '0) begin
            ras_pop   = 1'b1;
            m_pc_next = ras_top;
          end else begin
            underflow_set = 1'b1;
          end
        end
        OP_RSVD: begin
`ifdef UBUS_BRANCH_GT_EN
          if (dst_ok && dst_cur > ubus.imm) m_pc_next = ubus.mbranch_target;
`else
          illegal_set = 1'b1;
`endif
        end
        default: begin
          // NOP: only the micro-PC advances
        end
      endcase
    end
  end

  // State registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_state_reg     <= OUT_IDLE;
      dst_we_reg        <= '0;
      bus_data_reg      <= '0;
      m_pc_reg          <= '0;
      illegal_op_reg    <= 1'b0;
      ras_overflow_reg  <= 1'b0;
      ras_underflow_reg <= 1'b0;
      ras_wr_ptr_reg    <= '0;
      ras_count_reg     <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      out_state_reg     <= out_state_next;
      dst_we_reg        <= dst_we_next;
      bus_data_reg      <= bus_data_next;
      m_pc_reg          <= m_pc_next;
      illegal_op_reg    <= illegal_op_reg | illegal_set;
      ras_overflow_reg  <= ras_overflow_reg | overflow_set;
      ras_underflow_reg <= ras_underflow_reg | underflow_set;
      if (ras_push) begin
        // When full the write slot is the oldest entry, so it is overwritten
        ras_mem[ras_wr_ptr_reg] <= pc_inc;
        ras_wr_ptr_reg          <= ras_ptr_inc;
        if (!ras_full) ras_count_reg <= ras_count_reg + RAS_CNT_W'(1);
      end else if (ras_pop) begin
        ras_wr_ptr_reg <= ras_ptr_dec;
        ras_count_reg  <= ras_count_reg - RAS_CNT_W'(1);
      end
    end
  end

  assign ubus.minst_ready = !pend_busy;
  assign ubus.bus_data    = bus_data_reg;
  assign ubus.dst_we      = dst_we_reg;
  assign m_pc             = m_pc_reg;
  assign illegal_op       = illegal_op_reg;
  assign ras_overflow     = ras_overflow_reg;
  assign ras_underflow    = ras_underflow_reg;

endmodule

// File: tb/tb_ubus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ubus_xfer_ctrl
// Directed self-checking bench for ubus_xfer_ctrl with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ubus_xfer_ctrl;
  localparam int DW = 8;
  localparam int NS = 8;
  localparam int ND = 8;
  localparam int MW = 8;
  localparam int RD = 4;

  logic          clk;
  logic          rst_n;
  logic [MW-1:0] m_pc;
  logic          illegal_op;
  logic          ras_overflow;
  logic          ras_underflow;

  int n_checks;
  int n_errors;

  ubus_xfer_ctrl_if #(.DATA_WIDTH(DW), .NUM_SRC(NS), .NUM_DST(ND), .MPC_WIDTH(MW)) ubus ();

  ubus_xfer_ctrl #(
    .DATA_WIDTH(DW), .NUM_SRC(NS), .NUM_DST(ND), .MPC_WIDTH(MW), .RAS_DEPTH(RD)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .ubus         (ubus),
    .m_pc         (m_pc),
    .illegal_op   (illegal_op),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one instruction for one edge (caller ensures ready), then idle
  task automatic issue(input logic [2:0] typ, input logic [2:0] src, input logic [2:0] dst,
                       input logic [7:0] imm_v, input logic [7:0] tgt);
    ubus.minst_type     = typ;
    ubus.src_sel        = src;
    ubus.dst_sel        = dst;
    ubus.imm            = imm_v;
    ubus.mbranch_target = tgt;
    ubus.minst_valid    = 1'b1;
    $display("txn type=%0d src=%0d dst=%0d imm=0x%02h tgt=0x%02h pc=0x%02h", typ, src, dst, imm_v, tgt, m_pc);
    step();
    ubus.minst_valid = 1'b0;
    ubus.minst_type  = 3'd0;
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, illegal_op, ras_overflow, ras_underflow};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n               = 1'b0;
    ubus.minst_valid    = 1'b0;
    ubus.minst_type     = 3'd0;
    ubus.src_sel        = '0;
    ubus.dst_sel        = '0;
    ubus.imm            = '0;
    ubus.mbranch_target = '0;
    ubus.dst_busy       = '0;
    ubus.dst_data       = '0;
    for (int i = 0; i < NS; i++) ubus.src_data[i*DW +: DW] = 8'(8'h50 + i);
    ubus.src_data[3*DW +: DW] = 8'hA5;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_dst_we", 32'(ubus.dst_we), 32'h0);
    check("rst_bus",    32'(ubus.bus_data), 32'h0);
    check("rst_pc",     32'(m_pc), 32'h0);
    check("rst_flags",  flags(), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready",  32'(ubus.minst_ready), 32'h1);

    // MOVE src3 -> dst2
    issue(3'd1, 3'd3, 3'd2, 8'h00, 8'h00);
    check("move_we",  32'(ubus.dst_we), 32'h04);
    check("move_bus", 32'(ubus.bus_data), 32'hA5);
    check("move_pc",  32'(m_pc), 32'h01);
    step();
    check("move_we_clr", 32'(ubus.dst_we), 32'h0);

    // MOVI 0x3C -> dst5 with dst5 busy for three cycles, NOP waiting behind it
    issue(3'd2, 3'd0, 3'd5, 8'h3C, 8'h00);
    ubus.minst_valid = 1'b1;
    ubus.minst_type  = 3'd0;
    for (int i = 0; i < 3; i++) begin
      ubus.dst_busy = 8'h20;
      #1;
      check("movi_busy_we",    32'(ubus.dst_we), 32'h20);
      check("movi_busy_bus",   32'(ubus.bus_data), 32'h3C);
      check("movi_busy_ready", 32'(ubus.minst_ready), 32'h0);
      check("movi_busy_pc",    32'(m_pc), 32'h02);
      step();
    end
    ubus.dst_busy = 8'h00;
    #1;
    check("movi_free_we",    32'(ubus.dst_we), 32'h20);
    check("movi_free_ready", 32'(ubus.minst_ready), 32'h1);
    step();
    ubus.minst_valid = 1'b0;
    check("movi_done_we", 32'(ubus.dst_we), 32'h0);
    check("nop_pc",       32'(m_pc), 32'h03);

    // Back-to-back writes, one per cycle
    ubus.minst_valid = 1'b1;
    ubus.minst_type  = 3'd2;
    ubus.dst_sel     = 3'd0;
    ubus.imm         = 8'h11;
    step();
    ubus.dst_sel = 3'd7;
    ubus.imm     = 8'h77;
    check("b2b_we0",  32'(ubus.dst_we), 32'h01);
    check("b2b_bus0", 32'(ubus.bus_data), 32'h11);
    check("b2b_rdy",  32'(ubus.minst_ready), 32'h1);
    step();
    ubus.minst_valid = 1'b0;
    check("b2b_we1",  32'(ubus.dst_we), 32'h80);
    check("b2b_bus1", 32'(ubus.bus_data), 32'h77);
    step();
    check("b2b_clr", 32'(ubus.dst_we), 32'h0);
    check("b2b_pc",  32'(m_pc), 32'h05);

    // BREQ taken / not taken / full-width compare
    ubus.dst_data[1*DW +: DW] = 8'h07;
    issue(3'd3, 3'd0, 3'd1, 8'h07, 8'h40);
    check("breq_taken", 32'(m_pc), 32'h40);
    check("breq_no_we", 32'(ubus.dst_we), 32'h0);
    ubus.dst_data[1*DW +: DW] = 8'h06;
    issue(3'd3, 3'd0, 3'd1, 8'h07, 8'h40);
    check("breq_not", 32'(m_pc), 32'h41);
    ubus.dst_data[1*DW +: DW] = 8'h87;
    issue(3'd3, 3'd0, 3'd1, 8'h07, 8'h40);
    check("breq_msb", 32'(m_pc), 32'h42);

    // JMP, then CALL x5 overflowing the 4-entry RAS
    issue(3'd4, 3'd0, 3'd0, 8'h00, 8'h10);
    check("jmp_pc", 32'(m_pc), 32'h10);
    for (int i = 0; i < 5; i++) begin
      issue(3'd5, 3'd0, 3'd0, 8'h00, 8'(8'h20 + i));
      check("call_pc", 32'(m_pc), 32'(8'h20 + i));
      check("call_flags", flags(), (i == 4) ? 32'h2 : 32'h0);
    end

    // RET x5: four pops, then underflow
    for (int i = 0; i < 4; i++) begin
      issue(3'd6, 3'd0, 3'd0, 8'h00, 8'h00);
      check("ret_pc", 32'(m_pc), 32'(8'h24 - i));
    end
    issue(3'd6, 3'd0, 3'd0, 8'h00, 8'h00);
    check("ret_uf_pc",    32'(m_pc), 32'h22);
    check("ret_uf_flags", flags(), 32'h3);

    // Control instruction accepted while a write is completing
    issue(3'd2, 3'd0, 3'd3, 8'h5A, 8'h00);
    ubus.minst_valid    = 1'b1;
    ubus.minst_type     = 3'd4;
    ubus.mbranch_target = 8'h80;
    check("ctl_pend_we",  32'(ubus.dst_we), 32'h08);
    check("ctl_pend_rdy", 32'(ubus.minst_ready), 32'h1);
    step();
    ubus.minst_valid = 1'b0;
    check("ctl_jmp_pc", 32'(m_pc), 32'h80);
    check("ctl_we_clr", 32'(ubus.dst_we), 32'h0);

    // micro-PC wrap
    issue(3'd4, 3'd0, 3'd0, 8'h00, 8'hFF);
    issue(3'd0, 3'd0, 3'd0, 8'h00, 8'h00);
    check("wrap_pc", 32'(m_pc), 32'h00);

    // Type 7: BRGT when enabled, otherwise NOP + illegal_op
    ubus.dst_data[0 +: DW] = 8'h09;
    issue(3'd7, 3'd0, 3'd0, 8'h08, 8'h30);
`ifdef UBUS_BRANCH_GT_EN
    check("t7_pc",    32'(m_pc), 32'h30);
    check("t7_flags", flags(), 32'h3);
`else
    check("t7_pc",    32'(m_pc), 32'h01);
    check("t7_flags", flags(), 32'h7);
`endif

    // Asynchronous reset in the middle of a stalled write
    issue(3'd2, 3'd0, 3'd4, 8'h99, 8'h00);
    ubus.dst_busy = 8'h10;
    #1;
    check("ar_pend_we", 32'(ubus.dst_we), 32'h10);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_we",    32'(ubus.dst_we), 32'h0);
    check("ar_bus",   32'(ubus.bus_data), 32'h0);
    check("ar_pc",    32'(m_pc), 32'h0);
    check("ar_flags", flags(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
